// File: rtl/protocol_acc_pkg.sv
// Shared types and default widths for the protocol phase accumulator.
package protocol_acc_pkg;

  localparam int DATA_W = 14;
  localparam int SUM_W  = 48;
  localparam int CNT_W  = 32;
  localparam int SKIP_W = 16;
  localparam int IND_W  = 14;

  // Segment tracking states, exported on the debug state output.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SKIP  = 2'd2,
    ACCUM = 2'd3
  } acc_state_e;

endpackage

// File: rtl/protocol_phase_accumulator_if.sv
// Result bus from the accumulator to the readout/FIFO logic.
// Handshake: the producer raises valid_o with a stable payload
// (sum_o, count_o, phase_o); the payload stays unchanged while valid_o=1.
// A result is transferred in every cycle where valid_o && ready_i at the
// rising clock edge; ready_i may be driven independently of valid_o.
interface protocol_phase_accumulator_if #(
  parameter int SUM_W = 48,
  parameter int CNT_W = 32
);
  logic signed [SUM_W-1:0] sum_o;
  logic        [CNT_W-1:0] count_o;
  logic                    phase_o;
  logic                    valid_o;
  logic                    ready_i;

  modport master (output sum_o, output count_o, output phase_o, output valid_o,
                  input  ready_i);
  modport slave  (input  sum_o, input  count_o, input  phase_o, input  valid_o,
                  output ready_i);
endinterface

// File: rtl/segment_result_buffer.sv
// Single-entry holding register for finished segment results with
// valid/ready output, sticky overrun flag and synchronous clear.
module segment_result_buffer #(
  parameter int PAYLOAD_W = 81
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clear_i,
  input  logic                 emit_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic                 overrun_o
);

  // Load when empty or being drained this cycle; otherwise a new result is dropped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o   <= 1'b0;
      payload_o <= '0;
      overrun_o <= 1'b0;
    end else if (clear_i) begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (emit_i && (!valid_o || ready_i)) begin
      valid_o   <= 1'b1;
      payload_o <= payload_i;
    end else begin
      if (emit_i) overrun_o <= 1'b1;
      if (valid_o && ready_i) valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/protocol_phase_accumulator.sv
// Accumulates signed ADC samples over each whole protocol half-period and
// hands one {sum, count, phase} result per segment to the readout logic.
module protocol_phase_accumulator #(
  parameter int DATA_W = protocol_acc_pkg::DATA_W,
  parameter int SUM_W  = protocol_acc_pkg::SUM_W,
  parameter int CNT_W  = protocol_acc_pkg::CNT_W
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                enable_i,
  input  logic                                clear_i,
  input  logic [protocol_acc_pkg::IND_W-1:0]  indicator_i,
  input  logic signed [DATA_W-1:0]            adc_i,
  input  logic [protocol_acc_pkg::SKIP_W-1:0] skip_i,
  protocol_phase_accumulator_if.master        res,
  output logic                                overrun_o,
  output protocol_acc_pkg::acc_state_e        state_o
);

  localparam int SKIP_W    = protocol_acc_pkg::SKIP_W;
  localparam int IND_W     = protocol_acc_pkg::IND_W;
  localparam int PAYLOAD_W = SUM_W + CNT_W + 1;

  logic [IND_W-1:0]         ind_q;
  logic signed [DATA_W-1:0] adc_q;
  logic                     phase_q;
  logic                     phase_prev;
  logic                     transition;
  logic signed [SUM_W-1:0]  adc_ext;

  protocol_acc_pkg::acc_state_e state_q, state_d;
  logic signed [SUM_W-1:0]  acc_sum, sum_d;
  logic [CNT_W-1:0]         acc_cnt, cnt_d;
  logic [SKIP_W-1:0]        skip_cnt, skip_d;

  logic                     emit;
  logic [PAYLOAD_W-1:0]     emit_payload;
  logic [PAYLOAD_W-1:0]     held_payload;

  assign phase_q    = |ind_q;
  assign transition = phase_q ^ phase_prev;
  assign adc_ext    = {{(SUM_W-DATA_W){adc_q[DATA_W-1]}}, adc_q};
  assign state_o    = state_q;

  // Register the inputs once and remember the previous phase for edge detection.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ind_q      <= '0;
      adc_q      <= '0;
      phase_prev <= 1'b0;
    end else begin
      ind_q      <= indicator_i;
      adc_q      <= adc_i;
      phase_prev <= phase_q;
    end
  end

  // Next-state logic; a phase transition always restarts the segment with
  // the current sample counted as its first (skipped or accumulated) sample.
  always_comb begin
    state_d = state_q;
    sum_d   = acc_sum;
    cnt_d   = acc_cnt;
    skip_d  = skip_cnt;
    if (!enable_i) begin
      state_d = protocol_acc_pkg::IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      skip_d  = '0;
    end else begin
      case (state_q)
        protocol_acc_pkg::IDLE: begin
          state_d = protocol_acc_pkg::SYNC;
          sum_d   = '0;
          cnt_d   = '0;
          skip_d  = '0;
        end
        protocol_acc_pkg::SKIP: begin
          skip_d = skip_cnt - SKIP_W'(1);
          if (skip_cnt == SKIP_W'(1)) state_d = protocol_acc_pkg::ACCUM;
        end
        protocol_acc_pkg::ACCUM: begin
          // Count saturation freezes both sum and count until the segment ends.
          if (acc_cnt != {CNT_W{1'b1}}) begin
            sum_d = acc_sum + adc_ext;
            cnt_d = acc_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (transition && (state_q != protocol_acc_pkg::IDLE)) begin
        if (skip_i == '0) begin
          state_d = protocol_acc_pkg::ACCUM;
          sum_d   = adc_ext;
          cnt_d   = CNT_W'(1);
          skip_d  = '0;
        end else begin
          state_d = (skip_i == SKIP_W'(1)) ? protocol_acc_pkg::ACCUM : protocol_acc_pkg::SKIP;
          sum_d   = '0;
          cnt_d   = '0;
          skip_d  = skip_i - SKIP_W'(1);
        end
      end
    end
  end

  // Segment state and accumulator registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= protocol_acc_pkg::IDLE;
      acc_sum  <= '0;
      acc_cnt  <= '0;
      skip_cnt <= '0;
    end else begin
      state_q  <= state_d;
      acc_sum  <= sum_d;
      acc_cnt  <= cnt_d;
      skip_cnt <= skip_d;
    end
  end

  // Only a segment that started on a seen transition is reported; disabling
  // in the same cycle discards it.
  assign emit = enable_i && transition &&
                ((state_q == protocol_acc_pkg::SKIP) || (state_q == protocol_acc_pkg::ACCUM));
  assign emit_payload = {acc_sum, acc_cnt, phase_prev};

  segment_result_buffer #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_buf (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clear_i   (clear_i),
    .emit_i    (emit),
    .payload_i (emit_payload),
    .ready_i   (res.ready_i),
    .valid_o   (res.valid_o),
    .payload_o (held_payload),
    .overrun_o (overrun_o)
  );

  assign res.sum_o   = held_payload[PAYLOAD_W-1 -: SUM_W];
  assign res.count_o = held_payload[CNT_W:1];
  assign res.phase_o = held_payload[0];

endmodule

// File: tb/tb_protocol_phase_accumulator.sv
// Bench for protocol_phase_accumulator: directed protocol patterns plus
// random stimulus against a segment-list reference model.
module tb_protocol_phase_accumulator;
  import protocol_acc_pkg::*;

  localparam int PW = SUM_W + CNT_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                     enable, clear, ready;
  logic [IND_W-1:0]         ind;
  logic signed [DATA_W-1:0] adc;
  logic [SKIP_W-1:0]        skip;
  logic                     overrun;
  acc_state_e               state_dbg;

  protocol_phase_accumulator_if #(.SUM_W(SUM_W), .CNT_W(CNT_W)) res_if();
  assign res_if.ready_i = ready;

  protocol_phase_accumulator dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .enable_i    (enable),
    .clear_i     (clear),
    .indicator_i (ind),
    .adc_i       (adc),
    .skip_i      (skip),
    .res         (res_if),
    .overrun_o   (overrun),
    .state_o     (state_dbg)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Segments are kept as plain sample lists; the result is computed when the
  // segment closes by dropping the first skip samples and summing the rest.
  bit          m_phase, m_prev, m_ovr;
  int          m_adc;
  int          m_mode;       // 0 disabled, 1 waiting for first transition, 2 in segment
  int          seg_q[$];
  int          seg_skip;
  logic [PW-1:0] exp_q[$];   // scoreboard: at most one held result

  bit          dir_on, alt_on, have_last, last_ph;
  longint      dir_sum, dir_cnt;

  function automatic logic [PW-1:0] seg_result(input bit ph);
    longint s = 0;
    longint n = 0;
    for (int i = seg_skip; i < seg_q.size(); i++) begin
      s += seg_q[i];
      n++;
    end
    return {s[SUM_W-1:0], n[CNT_W-1:0], ph};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prev = 0; m_adc = 0; m_mode = 0; m_ovr = 0;
    seg_q.delete();
    exp_q.delete();
    seg_skip = 0;
  endtask

  task automatic model_step();
    bit trans = (m_phase != m_prev);
    bit emit = 0;
    bit held = (exp_q.size() != 0);
    logic [PW-1:0] r = '0;
    if (!enable) begin
      m_mode = 0;
      seg_q.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (trans) begin
      if (m_mode == 2) begin
        emit = 1;
        r = seg_result(m_prev);
      end
      seg_q.delete();
      seg_q.push_back(m_adc);
      seg_skip = int'(skip);
      m_mode = 2;
    end else if (m_mode == 2) begin
      seg_q.push_back(m_adc);
    end
    if (clear) begin
      exp_q.delete();
      m_ovr = 0;
    end else if (emit && (!held || ready)) begin
      exp_q.delete();
      exp_q.push_back(r);
    end else begin
      if (emit) m_ovr = 1;
      if (held && ready) exp_q.delete();
    end
    m_prev  = m_phase;
    m_phase = (ind != 0);
    m_adc   = adc;
  endtask

  task automatic check_all();
    logic [PW-1:0] e;
    check_eq("valid", res_if.valid_o, exp_q.size() != 0);
    check_eq("overrun", overrun, m_ovr);
    if (exp_q.size() != 0 && res_if.valid_o) begin
      e = exp_q[0];
      check_eq("sum", res_if.sum_o, $signed(e[PW-1 -: SUM_W]));
      check_eq("count", res_if.count_o, e[CNT_W:1]);
      check_eq("phase", res_if.phase_o, e[0]);
    end
    if (dir_on && res_if.valid_o) begin
      check_eq("dir_sum", res_if.sum_o, dir_sum);
      check_eq("dir_count", res_if.count_o, dir_cnt);
      if (alt_on) begin
        if (have_last) check_eq("alt_phase", res_if.phase_o, !last_ph);
        last_ph = res_if.phase_o;
        have_last = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Quiet gap: disable, drop any held result, park the indicator at phase 0,
  // then enable so the block is waiting for the first transition.
  task automatic gap();
    dir_on = 0; alt_on = 0; have_last = 0;
    enable = 0; clear = 1; ready = 1; ind = '0; adc = '0;
    tick();
    clear = 0;
    repeat (3) tick();
    enable = 1;
    repeat (3) tick();
  endtask

  task automatic run_pattern(input int seg_len, input int ncyc, input int skp, input bit alt_adc,
                             input longint es, input longint ec, input bit chk_alt,
                             input int abort_at);
    gap();
    skip = 16'(skp);
    dir_on = 1; alt_on = chk_alt; dir_sum = es; dir_cnt = ec;
    for (int p = 0; p < ncyc; p++) begin
      ind = (((p / seg_len) % 2) == 0) ? 14'd8191 : 14'd0;
      adc = alt_adc ? ((p % 2) ? 14'sd8191 : 14'(-8192)) : 14'sd100;
      if (abort_at >= 0) enable = !(p >= abort_at && p < abort_at + 3);
      tick();
    end
    dir_on = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int run_len = 0;
    int dis_len = 0;
    enable = 0; clear = 0; ready = 0; ind = '0; adc = '0; skip = '0;
    dir_on = 0; alt_on = 0; have_last = 0; last_ph = 0; dir_sum = 0; dir_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", res_if.valid_o, 0);
    check_eq("rst_sum", res_if.sum_o, 0);
    check_eq("rst_count", res_if.count_o, 0);
    check_eq("rst_phase", res_if.phase_o, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_state", state_dbg, IDLE);
    rstn = 1;

    // Disabled: random indicator activity must never produce a result.
    for (int c = 0; c < 100; c++) begin
      ind = 14'($urandom_range(0, 16383));
      adc = 14'($urandom);
      ready = 1'($urandom_range(0, 1));
      tick();
      check_eq("idle_valid", res_if.valid_o, 0);
    end

    // Nominal, long skip and mixed-sign patterns.
    run_pattern(10, 80, 2, 0, 800, 8, 1, -1);
    run_pattern(10, 60, 15, 0, 0, 0, 1, -1);
    run_pattern(6, 60, 0, 1, -3, 6, 1, -1);

    // Backpressure: first result held while later ones are dropped.
    gap();
    skip = 16'd2;
    for (int p = 0; p < 60; p++) begin
      ind = (((p / 10) % 2) == 0) ? 14'd8191 : 14'd0;
      adc = 14'sd100;
      ready = (p == 36);
      clear = (p == 37);
      tick();
      if (p == 25 || p == 35) begin
        check_eq("bp_valid", res_if.valid_o, 1);
        check_eq("bp_sum", res_if.sum_o, 800);
        check_eq("bp_count", res_if.count_o, 8);
        check_eq("bp_phase", res_if.phase_o, 1);
      end
      if (p == 35) check_eq("bp_ovr", overrun, 1);
      if (p == 36) check_eq("bp_drained", res_if.valid_o, 0);
      if (p == 37) check_eq("bp_clr_ovr", overrun, 0);
    end
    clear = 0;

    // Disable at sample 4 of the fourth segment, then re-enable.
    run_pattern(10, 90, 2, 0, 800, 8, 0, 33);

    // Random traffic against the model.
    gap();
    for (int c = 0; c < 3000; c++) begin
      if (run_len == 0) begin
        run_len = $urandom_range(1, 15);
        case ($urandom_range(0, 2))
          0: ind = '0;
          1: ind = 14'($urandom_range(1, 16383));
          default: ind = (ind == 0) ? 14'($urandom_range(1, 16383)) : 14'd0;
        endcase
        if ($urandom_range(0, 7) == 0) skip = 16'($urandom_range(0, 12));
      end
      run_len--;
      adc = 14'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 49) == 0);
      if (dis_len > 0) begin
        enable = 0;
        dis_len--;
      end else begin
        enable = 1;
        if ($urandom_range(0, 99) == 0) dis_len = $urandom_range(1, 5);
      end
      tick();
    end
    clear = 0;

    // Hold a result, then reset asynchronously between edges.
    ready = 0;
    repeat (30) tick();
    #3;
    rstn = 0;
    #1;
    check_eq("mid_rst_valid", res_if.valid_o, 0);
    check_eq("mid_rst_sum", res_if.sum_o, 0);
    check_eq("mid_rst_count", res_if.count_o, 0);
    check_eq("mid_rst_phase", res_if.phase_o, 0);
    check_eq("mid_rst_overrun", overrun, 0);
    check_eq("mid_rst_state", state_dbg, IDLE);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1;

    // Recovery after reset.
    run_pattern(10, 60, 2, 0, 800, 8, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit reached");
  end

endmodule
